// File: rtl/mips_bus_pkg.sv
// Shared types and pure helpers for the core-to-bus initiator: access sizes,
// FSM states, byte-lane enables, store-lane steering and load extraction.
package mips_bus_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CMD   = 2'd1,
      ST_RWAIT = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Size 3 is not an encodable size_t, so it is checked on the raw bits.
   function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'd0:    return 1'b0;
         2'd1:    return lo[0];
         2'd2:    return lo != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] gen_byteenable(input size_t size, input logic [1:0] lo);
      case (size)
         SIZE_BYTE: return 4'b0001 << lo;
         SIZE_HALF: return 4'b0011 << lo;
         default:   return 4'b1111;
      endcase
   endfunction

   // Replication lands the datum on whichever lanes the byteenable selects.
   function automatic logic [31:0] steer_wdata(input size_t size, input logic [31:0] wdata);
      case (size)
         SIZE_BYTE: return {4{wdata[7:0]}};
         SIZE_HALF: return {2{wdata[15:0]}};
         default:   return wdata;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] lo,
                                                input size_t size, input logic sign_ext);
      logic [7:0]  b;
      logic [15:0] h;
      b = rdata[{lo, 3'b000} +: 8];
      h = lo[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SIZE_BYTE: return sign_ext ? {{24{b[7]}}, b} : {24'd0, b};
         SIZE_HALF: return sign_ext ? {{16{h[15]}}, h} : {16'd0, h};
         default:   return rdata;
      endcase
   endfunction

endpackage

// File: rtl/mips_load_extract.sv
// Combinational load-data lane selection and zero/sign extension.
import mips_bus_pkg::*;

module mips_load_extract (
   input  logic [31:0] readdata,
   input  logic [1:0]  lo,
   input  size_t       size,
   input  logic        sign_ext,
   output logic [31:0] result
);

   assign result = load_extract(readdata, lo, size, sign_ext);

endmodule

// File: rtl/mips_bus_initiator.sv
// Turns one core load/store/fetch into one Avalon-style word-bus transaction,
// holding the command across waitrequest and returning exactly one response.
import mips_bus_pkg::*;

module mips_bus_initiator #(
   parameter int READ_LATENCY = 1,
   parameter int WAIT_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   input  logic        waitrequest,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic [31:0] readdata
);

   state_t      state, state_next;
   logic        is_write;
   logic [1:0]  addr_lo;
   size_t       size_q;
   logic        signed_q;
   logic [1:0]  lat_cnt;
   logic [31:0] stall_cnt;
   logic [31:0] rdata_q;
   logic        fault_q;
   logic [31:0] extracted;
   logic        req_bad;
   logic        timeout_hit;

   assign req_bad     = is_bad_req(req_size, req_addr[1:0]);
   assign timeout_hit = (WAIT_TIMEOUT != 0) && (stall_cnt + 32'd1 == 32'(WAIT_TIMEOUT));

   mips_load_extract u_extract (
      .readdata (readdata),
      .lo       (addr_lo),
      .size     (size_q),
      .sign_ext (signed_q),
      .result   (extracted)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      resp_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = req_bad ? ST_RESP : ST_CMD;
         end
         ST_CMD: begin
            read  = !is_write;
            write = is_write;
            if (!waitrequest)     state_next = is_write ? ST_RESP : ST_RWAIT;
            else if (timeout_hit) state_next = ST_RESP;
         end
         ST_RWAIT: begin
            if (lat_cnt == 2'd0) state_next = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Command and response registers; rdata/fault are cleared at acceptance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         address    <= 32'd0;
         byteenable <= 4'd0;
         writedata  <= 32'd0;
         is_write   <= 1'b0;
         addr_lo    <= 2'd0;
         size_q     <= SIZE_WORD;
         signed_q   <= 1'b0;
         lat_cnt    <= 2'd0;
         stall_cnt  <= 32'd0;
         rdata_q    <= 32'd0;
         fault_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  stall_cnt <= 32'd0;
                  rdata_q   <= 32'd0;
                  fault_q   <= req_bad;
                  if (!req_bad) begin
                     address    <= {req_addr[31:2], 2'b00};
                     byteenable <= gen_byteenable(size_t'(req_size), req_addr[1:0]);
                     writedata  <= steer_wdata(size_t'(req_size), req_wdata);
                     is_write   <= req_we;
                     addr_lo    <= req_addr[1:0];
                     size_q     <= size_t'(req_size);
                     signed_q   <= req_signed;
                  end
               end
            end
            ST_CMD: begin
               if (!waitrequest) begin
                  lat_cnt <= 2'(READ_LATENCY - 1);
               end else begin
                  stall_cnt <= stall_cnt + 32'd1;
                  if (timeout_hit) fault_q <= 1'b1;
               end
            end
            ST_RWAIT: begin
               if (lat_cnt == 2'd0) rdata_q <= extracted;
               else                 lat_cnt <= lat_cnt - 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign resp_rdata = resp_valid ? rdata_q : 32'd0;
   assign resp_fault = resp_valid & fault_q;

endmodule

// File: tb/tb_mips_bus_initiator.sv
// Directed bench: dut0 (READ_LATENCY=1, WAIT_TIMEOUT=8) and dut1 (READ_LATENCY=2, timeout off)
// share the core request fields; each has its own req_valid and bus responder signals.
module tb_mips_bus_initiator;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid [2];
   logic        req_we;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_wdata;
   logic        req_ready [2];
   logic        resp_valid [2];
   logic [31:0] resp_rdata [2];
   logic        resp_fault [2];
   logic [31:0] address [2];
   logic        read [2];
   logic        write [2];
   logic        waitrequest [2];
   logic [3:0]  byteenable [2];
   logic [31:0] writedata [2];
   logic [31:0] readdata [2];

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   mips_bus_initiator #(.READ_LATENCY(1), .WAIT_TIMEOUT(8)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
      .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]),
      .address(address[0]), .read(read[0]), .write(write[0]), .waitrequest(waitrequest[0]),
      .byteenable(byteenable[0]), .writedata(writedata[0]), .readdata(readdata[0])
   );

   mips_bus_initiator #(.READ_LATENCY(2), .WAIT_TIMEOUT(0)) dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
      .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]),
      .address(address[1]), .read(read[1]), .write(write[1]), .waitrequest(waitrequest[1]),
      .byteenable(byteenable[1]), .writedata(writedata[1]), .readdata(readdata[1])
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int d, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic sgn, input logic [31:0] wdata);
      req_valid[d] = 1'b1;
      req_we       = we;
      req_addr     = addr;
      req_size     = size;
      req_signed   = sgn;
      req_wdata    = wdata;
   endtask

   // Core fields are trashed after acceptance; the transaction must not notice.
   task automatic scramble(input int d);
      req_valid[d] = 1'b0;
      req_we       = ~req_we;
      req_addr     = 32'hFFFF_FFFF;
      req_size     = 2'd3;
      req_signed   = ~req_signed;
      req_wdata    = 32'h0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if ({read[0], write[0], resp_valid[0], resp_fault[0], req_ready[0]} !== 5'b00001)
         $display("FAIL reset_ctl: got %b want 00001", {read[0], write[0], resp_valid[0], resp_fault[0], req_ready[0]});
      else passes++;
      checks++; if (address[0] !== 32'd0) $display("FAIL reset_addr: got %h want 0", address[0]); else passes++;
      checks++; if (writedata[0] !== 32'd0 || byteenable[0] !== 4'd0)
         $display("FAIL reset_wd_be: got %h/%b want 0/0000", writedata[0], byteenable[0]);
      else passes++;
      checks++; if (resp_rdata[0] !== 32'd0) $display("FAIL reset_rdata: got %h want 0", resp_rdata[0]); else passes++;
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_word_store();
      issue(0, 1'b1, 32'h0000_0010, 2'd2, 1'b0, 32'hDEAD_BEEF);
      waitrequest[0] = 1'b0;
      tick(); scramble(0);
      checks++; if ({write[0], read[0], req_ready[0]} !== 3'b100)
         $display("FAIL st_strobe: got %b want 100", {write[0], read[0], req_ready[0]});
      else passes++;
      checks++; if (address[0] !== 32'h10 || byteenable[0] !== 4'b1111)
         $display("FAIL st_addr_be: got %h/%b want 00000010/1111", address[0], byteenable[0]);
      else passes++;
      checks++; if (writedata[0] !== 32'hDEAD_BEEF) $display("FAIL st_wdata: got %h want deadbeef", writedata[0]); else passes++;
      tick();
      checks++; if ({write[0], resp_valid[0], resp_fault[0]} !== 3'b010 || resp_rdata[0] !== 32'd0)
         $display("FAIL st_resp: got %b rdata %h want 010 rdata 0", {write[0], resp_valid[0], resp_fault[0]}, resp_rdata[0]);
      else passes++;
      tick();
      checks++; if ({resp_valid[0], req_ready[0]} !== 2'b01)
         $display("FAIL st_idle: got %b want 01", {resp_valid[0], req_ready[0]});
      else passes++;
   endtask

   task automatic test_stalled_byte_load();
      issue(0, 1'b0, 32'h0000_0013, 2'd0, 1'b1, 32'h0);
      waitrequest[0] = 1'b1;
      tick(); scramble(0);
      for (int i = 0; i < 4; i++) begin
         checks++; if (read[0] !== 1'b1 || write[0] !== 1'b0 || address[0] !== 32'h10 || byteenable[0] !== 4'b1000)
            $display("FAIL stall_hold%0d: got rd%b wr%b %h %b want rd1 wr0 00000010 1000", i, read[0], write[0], address[0], byteenable[0]);
         else passes++;
         if (i == 3) waitrequest[0] = 1'b0;
         tick();
      end
      readdata[0] = 32'h80FF_0000;
      checks++; if (read[0] !== 1'b0 || resp_valid[0] !== 1'b0)
         $display("FAIL stall_drop: got rd%b rv%b want 0 0", read[0], resp_valid[0]);
      else passes++;
      tick();
      readdata[0] = 32'h5A5A_5A5A;
      checks++; if (resp_valid[0] !== 1'b1 || resp_fault[0] !== 1'b0 || resp_rdata[0] !== 32'hFFFF_FF80)
         $display("FAIL sbyte_resp: got v%b f%b %h want v1 f0 ffffff80", resp_valid[0], resp_fault[0], resp_rdata[0]);
      else passes++;
      tick();
   endtask

   task automatic test_half_load(input int d, input int rl);
      issue(d, 1'b0, 32'hBFC0_0002, 2'd1, 1'b0, 32'h0);
      waitrequest[d] = 1'b0;
      tick(); scramble(d);
      checks++; if (read[d] !== 1'b1 || byteenable[d] !== 4'b1100 || address[d] !== 32'hBFC0_0000)
         $display("FAIL half_cmd%0d: got rd%b %b %h want rd1 1100 bfc00000", d, read[d], byteenable[d], address[d]);
      else passes++;
      tick();
      for (int k = 1; k < rl; k++) begin
         checks++; if (resp_valid[d] !== 1'b0 || read[d] !== 1'b0)
            $display("FAIL half_wait%0d: got rv%b rd%b want 0 0", d, resp_valid[d], read[d]);
         else passes++;
         tick();
      end
      readdata[d] = 32'h8001_1234;
      checks++; if (resp_valid[d] !== 1'b0) $display("FAIL half_early%0d: got %b want 0", d, resp_valid[d]); else passes++;
      tick();
      readdata[d] = 32'h5A5A_5A5A;
      checks++; if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== 32'h0000_8001)
         $display("FAIL half_resp%0d: got v%b %h want v1 00008001", d, resp_valid[d], resp_rdata[d]);
      else passes++;
      tick();
      checks++; if (resp_valid[d] !== 1'b0) $display("FAIL half_once%0d: got %b want 0", d, resp_valid[d]); else passes++;
   endtask

   task automatic test_loads();
      logic [31:0] ad [5] = '{32'h12, 32'h01, 32'h02, 32'h00, 32'h08};
      logic [1:0]  sz [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
      logic        sg [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [31:0] wd [5] = '{32'h80FF_0000, 32'h0000_C300, 32'h8001_1234, 32'h8001_1234, 32'hCAFE_F00D};
      logic [3:0]  be [5] = '{4'b0100, 4'b0010, 4'b1100, 4'b0011, 4'b1111};
      logic [31:0] ex [5] = '{32'h0000_00FF, 32'hFFFF_FFC3, 32'hFFFF_8001, 32'h0000_1234, 32'hCAFE_F00D};
      for (int i = 0; i < 5; i++) begin
         issue(0, 1'b0, ad[i], sz[i], sg[i], 32'h0);
         tick(); scramble(0);
         checks++; if (byteenable[0] !== be[i]) $display("FAIL load_be%0d: got %b want %b", i, byteenable[0], be[i]); else passes++;
         tick();
         readdata[0] = wd[i];
         tick();
         readdata[0] = 32'h5A5A_5A5A;
         checks++; if (resp_valid[0] !== 1'b1 || resp_fault[0] !== 1'b0 || resp_rdata[0] !== ex[i])
            $display("FAIL load_data%0d: got v%b f%b %h want v1 f0 %h", i, resp_valid[0], resp_fault[0], resp_rdata[0], ex[i]);
         else passes++;
         tick();
      end
   endtask

   task automatic test_faults();
      logic        we [3] = '{1'b1, 1'b0, 1'b0};
      logic [31:0] ad [3] = '{32'h5, 32'h2, 32'h0};
      logic [1:0]  sz [3] = '{2'd1, 2'd2, 2'd3};
      for (int i = 0; i < 3; i++) begin
         issue(0, we[i], ad[i], sz[i], 1'b0, 32'hFFFF_FFFF);
         tick(); scramble(0);
         checks++; if ({resp_valid[0], resp_fault[0], read[0], write[0]} !== 4'b1100 || resp_rdata[0] !== 32'd0)
            $display("FAIL fault_resp%0d: got %b %h want 1100 0", i, {resp_valid[0], resp_fault[0], read[0], write[0]}, resp_rdata[0]);
         else passes++;
         tick();
         checks++; if ({resp_valid[0], read[0], write[0], req_ready[0]} !== 4'b0001)
            $display("FAIL fault_after%0d: got %b want 0001", i, {resp_valid[0], read[0], write[0], req_ready[0]});
         else passes++;
      end
   endtask

   task automatic test_timeout();
      issue(0, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
      waitrequest[0] = 1'b1;
      tick(); scramble(0);
      for (int i = 0; i < 8; i++) begin
         checks++; if (read[0] !== 1'b1 || resp_valid[0] !== 1'b0)
            $display("FAIL tmo_stall%0d: got rd%b rv%b want 1 0", i, read[0], resp_valid[0]);
         else passes++;
         tick();
      end
      checks++; if ({read[0], resp_valid[0], resp_fault[0]} !== 3'b011 || resp_rdata[0] !== 32'd0)
         $display("FAIL tmo_resp: got %b %h want 011 0", {read[0], resp_valid[0], resp_fault[0]}, resp_rdata[0]);
      else passes++;
      tick();
      waitrequest[0] = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] ad [3] = '{32'h24, 32'h06, 32'h02};
      logic [1:0]  sz [3] = '{2'd2, 2'd0, 2'd1};
      logic [31:0] wd [3] = '{32'h1122_3344, 32'h0000_00AB, 32'h0000_BEEF};
      logic [31:0] wa [3] = '{32'h24, 32'h04, 32'h00};
      logic [3:0]  be [3] = '{4'b1111, 4'b0100, 4'b1100};
      logic [31:0] mk [3] = '{32'hFFFF_FFFF, 32'h00FF_0000, 32'hFFFF_0000};
      logic [31:0] ex [3] = '{32'h1122_3344, 32'h00AB_0000, 32'hBEEF_0000};
      for (int i = 0; i < 3; i++) begin
         checks++; if (req_ready[0] !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", i, req_ready[0]); else passes++;
         issue(0, 1'b1, ad[i], sz[i], 1'b0, wd[i]);
         tick(); scramble(0);
         checks++; if (write[0] !== 1'b1 || address[0] !== wa[i] || byteenable[0] !== be[i] || (writedata[0] & mk[i]) !== ex[i])
            $display("FAIL b2b_cmd%0d: got wr%b %h %b %h want wr1 %h %b %h", i, write[0], address[0], byteenable[0],
                     writedata[0] & mk[i], wa[i], be[i], ex[i]);
         else passes++;
         tick();
         checks++; if ({write[0], resp_valid[0], resp_fault[0]} !== 3'b010)
            $display("FAIL b2b_resp%0d: got %b want 010", i, {write[0], resp_valid[0], resp_fault[0]});
         else passes++;
         tick();
      end
   endtask

   task automatic test_reset_abort();
      issue(0, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
      waitrequest[0] = 1'b1;
      tick(); scramble(0);
      tick();
      checks++; if (read[0] !== 1'b1) $display("FAIL abort_pre: got %b want 1", read[0]); else passes++;
      #2 reset = 1'b0;
      #1;
      checks++; if (read[0] !== 1'b0 || req_ready[0] !== 1'b1)
         $display("FAIL abort_async: got rd%b rdy%b want 0 1", read[0], req_ready[0]);
      else passes++;
      tick();
      checks++; if (resp_valid[0] !== 1'b0) $display("FAIL abort_noresp: got %b want 0", resp_valid[0]); else passes++;
      @(negedge clk);
      reset = 1'b1;
      waitrequest[0] = 1'b0;
      tick();
      checks++; if ({req_ready[0], resp_valid[0], read[0], write[0]} !== 4'b1000)
         $display("FAIL abort_after: got %b want 1000", {req_ready[0], resp_valid[0], read[0], write[0]});
      else passes++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset          = 1'b0;
      req_valid[0]   = 1'b0;
      req_valid[1]   = 1'b0;
      req_we         = 1'b0;
      req_addr       = 32'h0;
      req_size       = 2'd0;
      req_signed     = 1'b0;
      req_wdata      = 32'h0;
      waitrequest[0] = 1'b0;
      waitrequest[1] = 1'b0;
      readdata[0]    = 32'h5A5A_5A5A;
      readdata[1]    = 32'h5A5A_5A5A;
      test_reset();
      test_word_store();
      test_stalled_byte_load();
      test_half_load(0, 1);
      test_half_load(1, 2);
      test_loads();
      test_faults();
      test_timeout();
      test_back_to_back();
      test_reset_abort();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
